universal_shift_engine: RTL and testbench

//  Parametrised successor to the 4-bit universal shift register. It runs a multi-step shift or rotate

---
 rtl/shreg_pkg.sv | 29 ++
 rtl/universal_shift_engine_if.sv | 40 ++++
 rtl/shreg_step_unit.sv | 57 +++++
 rtl/universal_shift_engine.sv | 126 ++++++++++++
 tb/tb_universal_shift_engine.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/shreg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shreg_pkg
//  Purpose  : Shared types for the universal shift engine: the command opcode
//             encoding and the engine FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package shreg_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_SLL   = 3'b001,
        OP_SRL   = 3'b010,
        OP_SRA   = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_CLEAR = 3'b110,
        OP_NOP   = 3'b111
    } shreg_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } shreg_state_e;

endpackage : shreg_pkg
`default_nettype wire

// File: rtl/universal_shift_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_engine_if
//  Purpose  : Command handshake, data and status bundle of the shift engine.
//  Ports    : master = command source (drives i_*, observes o_*)
//             slave  = engine side (observes i_*, drives o_*)
//             i_cmd_valid/o_cmd_ready handshake, i_cmd_op, i_cmd_amt,
//             i_load, i_sin, i_abort, o_q, o_sout, o_busy, o_done, o_parity
//  Revision : 1.0  initial release
// ============================================================================
interface universal_shift_engine_if #(
    parameter int WIDTH   = 4,
    parameter int MAX_AMT = WIDTH
) ();
    localparam int AMT_W = $clog2(MAX_AMT + 1);

    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    shreg_pkg::shreg_op_e  i_cmd_op;
    logic [AMT_W-1:0]      i_cmd_amt;
    logic [WIDTH-1:0]      i_load;
    logic                  i_sin;
    logic                  i_abort;
    logic [WIDTH-1:0]      o_q;
    logic                  o_sout;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_parity;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_amt, i_load, i_sin, i_abort,
        input  o_cmd_ready, o_q, o_sout, o_busy, o_done, o_parity
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_amt, i_load, i_sin, i_abort,
        output o_cmd_ready, o_q, o_sout, o_busy, o_done, o_parity
    );
endinterface : universal_shift_engine_if
`default_nettype wire

// File: rtl/shreg_step_unit.sv
`default_nettype none
// ============================================================================
//  Module   : shreg_step_unit
//  Purpose  : Combinational single-bit shift/rotate step.
//  Ports    : i_op      operation (only SLL/SRL/SRA/ROL/ROR move data)
//             i_q       current register value
//             i_sin     serial fill bit for SLL/SRL
//             o_q_next  register value after one step
//             o_sout    bit ejected by the step (0 for non-shift ops)
//  Revision : 1.0  initial release
// ============================================================================
module shreg_step_unit
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  shreg_op_e         i_op,
    input  logic [WIDTH-1:0]  i_q,
    input  logic              i_sin,
    output logic [WIDTH-1:0]  o_q_next,
    output logic              o_sout
);

    always_comb begin
        o_q_next = i_q;
        o_sout   = 1'b0;
        case (i_op)
            OP_SLL: begin
                o_q_next = {i_q[WIDTH-2:0], i_sin};
                o_sout   = i_q[WIDTH-1];
            end
            OP_SRL: begin
                o_q_next = {i_sin, i_q[WIDTH-1:1]};
                o_sout   = i_q[0];
            end
            OP_SRA: begin
                // sign bit is replicated, so the MSB keeps its old value
                o_q_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
                o_sout   = i_q[0];
            end
            OP_ROL: begin
                o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_sout   = i_q[WIDTH-1];
            end
            OP_ROR: begin
                o_q_next = {i_q[0], i_q[WIDTH-1:1]};
                o_sout   = i_q[0];
            end
            default: begin
                o_q_next = i_q;
                o_sout   = 1'b0;
            end
        endcase
    end

endmodule : shreg_step_unit
`default_nettype wire

// File: rtl/universal_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_engine
//  Purpose  : Multi-step shift/rotate engine, one bit per clock, with parallel
//             load, clear, serial in/out, arithmetic shift and abort.
//             Commands arrive on a valid/ready handshake; o_done pulses for
//             one cycle on completion.
//  Ports    : i_clk  clock (rising edge)
//             i_rst  asynchronous reset, active-high
//             bus    universal_shift_engine_if.slave (command + status bundle)
//  Config   : SHREG_PARITY_EN - when defined, o_parity = ^o_q;
//             otherwise o_parity is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module universal_shift_engine
    import shreg_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_AMT = WIDTH
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst,
    universal_shift_engine_if.slave   bus
);

    localparam int AMT_W = $clog2(MAX_AMT + 1);
    localparam logic [AMT_W-1:0] c_max_amt = AMT_W'(MAX_AMT);
    localparam logic [AMT_W-1:0] c_one_amt = AMT_W'(1);

    shreg_state_e      state_q, state_d;
    shreg_op_e         op_q,    op_d;
    logic [AMT_W-1:0]  cnt_q,   cnt_d;
    logic [WIDTH-1:0]  q_q,     q_d;
    logic              sout_q,  sout_d;

    logic [AMT_W-1:0]  w_amt_sat;
    logic [WIDTH-1:0]  w_step_q;
    logic              w_step_sout;

    // Oversized step counts are clamped rather than wrapped.
    assign w_amt_sat = (bus.i_cmd_amt > c_max_amt) ? c_max_amt : bus.i_cmd_amt;

    shreg_step_unit #(
        .WIDTH    (WIDTH)
    ) u_step (
        .i_op     (op_q),
        .i_q      (q_q),
        .i_sin    (bus.i_sin),
        .o_q_next (w_step_q),
        .o_sout   (w_step_sout)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    // one-shot commands finish at the accept edge
                    state_d = DONE;
                    case (bus.i_cmd_op)
                        OP_LOAD:  q_d = bus.i_load;
                        OP_CLEAR: q_d = '0;
                        OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
                            if (w_amt_sat != '0) begin
                                op_d    = bus.i_cmd_op;
                                cnt_d   = w_amt_sat;
                                state_d = RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (bus.i_abort) begin
                    // partial result in q/sout is kept deliberately
                    state_d = IDLE;
                end else begin
                    q_d    = w_step_q;
                    sout_d = w_step_sout;
                    cnt_d  = cnt_q - c_one_amt;
                    if (cnt_q == c_one_amt) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
        end
    end

    // Ready is withheld while reset is asserted so no command is seen as taken.
    assign bus.o_cmd_ready = (state_q == IDLE) && !i_rst;
    assign bus.o_busy      = (state_q == RUN);
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_q         = q_q;
    assign bus.o_sout      = sout_q;

`ifdef SHREG_PARITY_EN
    assign bus.o_parity = ^q_q;
`else
    assign bus.o_parity = 1'b0;
`endif

endmodule : universal_shift_engine
`default_nettype wire

// File: tb/tb_universal_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_universal_shift_engine
//  Purpose  : Self-checking bench for universal_shift_engine (WIDTH=4,
//             MAX_AMT=4). Directed scenarios followed by random commands,
//             all compared against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_universal_shift_engine;
    import shreg_pkg::*;

    localparam int W   = 4;
    localparam int MA  = 4;
    localparam int MOD = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    universal_shift_engine_if #(.WIDTH(W), .MAX_AMT(MA)) bus ();

    universal_shift_engine #(
        .WIDTH   (W),
        .MAX_AMT (MA)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_q    = 0;
    int m_sout = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_parity(input int v);
`ifdef SHREG_PARITY_EN
        return $countones(v % MOD) % 2;
`else
        return (v < 0) ? 1 : 0;  // v is never negative: always 0
`endif
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_q"},      bus.o_q,      m_q);
        chk({tag, "_sout"},   bus.o_sout,   m_sout);
        chk({tag, "_parity"}, bus.o_parity, exp_parity(m_q));
    endtask

    // One step expressed with plain integer arithmetic.
    task automatic mstep(input int op, input int sin);
        int b;
        case (op)
            1: begin m_sout = m_q / 8; m_q = (m_q * 2 + sin) % MOD; end
            2: begin m_sout = m_q % 2; m_q = m_q / 2 + sin * 8; end
            3: begin m_sout = m_q % 2; m_q = m_q / 2 + ((m_q >= 8) ? 8 : 0); end
            4: begin b = m_q / 8; m_q = (m_q * 2) % MOD + b; m_sout = b; end
            5: begin b = m_q % 2; m_q = m_q / 2 + b * 8; m_sout = b; end
            default: ;
        endcase
    endtask

    // sin_mode: 0/1 fixed fill bit, 2 random per step.
    // abort_step: 0 none, else abort asserted before the edge of that step.
    task automatic do_cmd(input int op, input int amt, input int ld, input int sin_mode,
                          input int abort_step, input bit hold_valid, input bit idle_abort);
        int n;
        int sb;
        @(negedge clk);
        chk("ready_idle", bus.o_cmd_ready, 1);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = shreg_op_e'(op[2:0]);
        bus.i_cmd_amt   = 3'(amt);
        bus.i_load      = 4'(ld);
        bus.i_sin       = (sin_mode == 1);
        bus.i_abort     = idle_abort;
        @(posedge clk);
        #1;
        bus.i_abort = 1'b0;
        if (hold_valid) bus.i_cmd_op = OP_CLEAR;
        else            bus.i_cmd_valid = 1'b0;

        n = (op >= 1 && op <= 5) ? ((amt > MA) ? MA : amt) : 0;
        if (n == 0) begin
            if (op == 0) m_q = ld % MOD;
            if (op == 6) m_q = 0;
        end

        for (int s = 1; s <= n; s++) begin
            @(negedge clk);
            if (s > 1) check_outputs("step");
            chk("busy_run",  bus.o_busy,      1);
            chk("done_run",  bus.o_done,      0);
            chk("ready_run", bus.o_cmd_ready, 0);
            if (s == abort_step) begin
                bus.i_abort = 1'b1;
                @(posedge clk);
                #1;
                bus.i_abort     = 1'b0;
                bus.i_cmd_valid = 1'b0;
                @(negedge clk);
                chk("abort_busy",  bus.o_busy,      0);
                chk("abort_done",  bus.o_done,      0);
                chk("abort_ready", bus.o_cmd_ready, 1);
                check_outputs("abort");
                @(negedge clk);
                chk("abort_no_done", bus.o_done, 0);
                return;
            end
            sb = (sin_mode == 2) ? int'($urandom_range(0, 1)) : sin_mode;
            bus.i_sin = sb[0];
            mstep(op, sb);
            @(posedge clk);
        end

        @(negedge clk);
        chk("done_pulse", bus.o_done,      1);
        chk("done_busy",  bus.o_busy,      0);
        chk("done_ready", bus.o_cmd_ready, 0);
        check_outputs("done");
        bus.i_cmd_valid = 1'b0;
        @(negedge clk);
        chk("done_end",   bus.o_done,      0);
        chk("idle_ready", bus.o_cmd_ready, 1);
    endtask

    task automatic reset_mid_run();
        int seen_done;
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = OP_ROL;
        bus.i_cmd_amt   = 3'd4;
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
        @(posedge clk);            // first step
        @(negedge clk);
        chk("rstmid_busy_before", bus.o_busy, 1);
        rst = 1'b1;
        #1;
        m_q = 0;
        m_sout = 0;
        check_outputs("rstmid");
        chk("rstmid_busy", bus.o_busy, 0);
        chk("rstmid_done", bus.o_done, 0);
        #2 rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_done !== 1'b0) seen_done++;
        end
        chk("rstmid_never_done", seen_done, 0);
        chk("rstmid_ready", bus.o_cmd_ready, 1);
        check_outputs("rstmid_hold");
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = OP_NOP;
        bus.i_cmd_amt   = '0;
        bus.i_load      = '0;
        bus.i_sin       = 1'b0;
        bus.i_abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset_busy", bus.o_busy, 0);
        chk("reset_done", bus.o_done, 0);
        rst = 1'b0;

        // directed scenarios
        do_cmd(0, 0, 4'b1010, 0, 0, 0, 0);
        do_cmd(2, 2, 0,       1, 0, 0, 0);      // 1101/0 then 1110/1
        do_cmd(0, 0, 4'b1000, 0, 0, 0, 0);
        do_cmd(3, 3, 0,       0, 0, 0, 0);      // -> 1111
        do_cmd(0, 0, 4'b1001, 0, 0, 0, 0);
        do_cmd(4, 1, 0,       0, 0, 0, 0);      // -> 0011
        do_cmd(0, 0, 4'b1001, 0, 0, 0, 0);
        do_cmd(5, 4, 0,       0, 0, 0, 0);      // -> 1001
        do_cmd(1, 0, 0,       1, 0, 0, 0);      // amt 0: unchanged
        do_cmd(1, 7, 0,       2, 0, 0, 0);      // saturates to 4 steps
        do_cmd(0, 0, 4'b1000, 0, 0, 0, 0);
        do_cmd(4, 4, 0,       0, 2, 0, 0);      // abort -> 0001
        do_cmd(2, 3, 0,       1, 0, 1, 0);      // valid held in RUN
        do_cmd(7, 2, 4'b1111, 0, 0, 0, 1);      // NOP, abort in IDLE
        do_cmd(0, 0, 4'b0111, 0, 0, 0, 0);      // parity 1 when enabled
        do_cmd(0, 0, 4'b0110, 0, 0, 0, 0);      // parity 0
        do_cmd(6, 0, 0,       0, 0, 0, 0);      // CLEAR
        do_cmd(0, 0, 4'b1011, 0, 0, 0, 0);
        reset_mid_run();

        // random commands
        for (int i = 0; i < 120; i++) begin
            int op, amt, ab;
            op  = int'($urandom_range(0, 7));
            amt = int'($urandom_range(0, 7));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_cmd(op, amt, int'($urandom_range(0, 15)), 2, ab,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_universal_shift_engine
`default_nettype wire
